sram_access_ctrl: RTL and testbench
===================================

// Module: sram_access_ctrl
// PURPOSE
//  Downstream of the two-master request mux. Consumes the muxed request (addr/wr/cs/rw) and runs one
//  timed asynchronous-SRAM bus cycle per accepted request: setup, access (wait states), hold.
//  Returns read data and a one-cycle ready pulse.
//  Single clock domain. All outputs are registered.
// PARAMETERS
//  ADDR_W     22  request/SRAM address width
//  DATA_W     32  data width
//  SETUP_CYC  1   cycles with address/CE valid before strobe (>=1)
//  WAIT_CYC   2   cycles with OE_n/WE_n strobe low (>=1)
//  HOLD_CYC   1   cycles with address/CE/data held after strobe (>=1)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous reset, active high
//  addr        in   ADDR_W  request address
//  wr          in   DATA_W  write data
//  cs          in   1       request valid (level)
//  rw          in   1       1=read, 0=write
//  rd          out  DATA_W  read data; valid when ready=1, held until next read completes
//  ready       out  1       one-cycle completion pulse
//  busy        out  1       high from acceptance through the ready cycle
//  sram_addr   out  ADDR_W  SRAM address
//  sram_dq_o   out  DATA_W  SRAM write data
//  sram_dq_oe  out  1       SRAM data-bus drive enable
//  sram_dq_i   in   DATA_W  SRAM read data
//  sram_ce_n   out  1       chip enable, active low
//  sram_oe_n   out  1       output enable, active low
//  sram_we_n   out  1       write enable, active low
//  sram_wait_n in   1       memory wait, active low (only with SRAM_WAIT_EN)
// BEHAVIOUR
//  - Reset (sync, any state): state=IDLE; rd=0; sram_addr=0; sram_dq_o=0; ready=0; busy=0.
//    sram_dq_oe=0; ce_n/oe_n/we_n=1. An aborted access never produces a ready pulse.
//  - FSM: IDLE -> SETUP -> ACCESS -> HOLD -> DONE -> IDLE.
//    - One down-counter is loaded with N-1 on state entry. Leave SETUP/ACCESS/HOLD when count==0.
//  - IDLE: when cs=1, latch addr, wr and rw and go to SETUP.
//    - busy=1 from the next cycle.
//    - addr/wr/cs/rw are ignored in every other state, including DONE.
//  - SETUP: ce_n=0, sram_addr=latched address.
//    - For a write: dq_oe=1 and dq_o=latched data.
//  - ACCESS: ce_n=0, plus the strobe for the cycle type.
//    - Read: oe_n=0. sram_dq_i is captured into rd on the final ACCESS edge.
//    - Write: we_n=0 and dq_oe=1.
//  - HOLD: ce_n=0 and oe_n/we_n=1. For a write, dq_oe=1 and dq_o are held.
//  - DONE: ready=1 and busy=1 for exactly one cycle; all strobes idle, dq_oe=0.
//  - sram_addr and sram_dq_o are stable from SETUP through HOLD.
//    - sram_dq_oe is never 1 during a read cycle.
//  - Latency: a request accepted in cycle 0 gives ready in cycle 1+SETUP_CYC+WAIT_CYC+HOLD_CYC.
//    With defaults, ready is in cycle 5.
//  - Back-to-back: cs held high is re-sampled in the IDLE cycle after DONE.
//    Minimum request period is SETUP_CYC+WAIT_CYC+HOLD_CYC+2 (defaults: 6).
//    Upstream drops cs on ready if it has no new request.
// CONFIGURATION
//  - SRAM_WAIT_EN defined:
//    - Adds port sram_wait_n.
//    - When the ACCESS count reaches 0 and sram_wait_n=0, stay in ACCESS with the strobe held.
//      Exit on the first edge where count==0 and sram_wait_n=1; rd is captured on that edge.
//    - Reset aborts a stretched access.
//  - SRAM_WAIT_EN undefined: port absent and ACCESS is exactly WAIT_CYC cycles.
// TESTING
//  1 Reset: rst=1 for 2 cycles mid-idle.
//    -> ce_n=oe_n=we_n=1, dq_oe=0, ready=0, busy=0, rd=0.
//  2 Write: addr=22'h3FFFFF, wr=32'hDEADBEEF, rw=0, cs pulse in cycle 0.
//    -> ce_n=0 in cycles 1-4; we_n=0 in cycles 2-3 only; dq_o=DEADBEEF and dq_oe=1 in cycles 1-4.
//    -> ready=1 in cycle 5 only.
//  3 Read: addr=22'h000155, rw=1, sram_dq_i=32'hA5A50F0F in cycles 2-3.
//    -> oe_n=0 in cycles 2-3; dq_oe=0 throughout; rd=A5A50F0F with ready=1 in cycle 5.
//  4 Back-to-back: cs held high with a write then a read.
//    -> second SETUP in cycle 7, second ready in cycle 11.
//    -> request changes during busy or DONE have no effect.
//  5 Reset in cycle 2 (ACCESS) of a write.
//    -> cycle 3: we_n=ce_n=1, dq_oe=0, busy=0; no ready pulse.
//    -> a new request in cycle 4 completes normally.
//  6 SRAM_WAIT_EN: read with sram_wait_n=0 in cycles 3-5.
//    -> oe_n=0 in cycles 2-6; rd captured at end of cycle 6; ready in cycle 8.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Runs one timed asynchronous-SRAM bus cycle per accepted request.
//   Each cycle has a setup phase, an access (strobe) phase and a hold phase,
//   followed by a single DONE cycle that pulses ready. All outputs are
//   registered: the next-state logic also computes the next output values,
//   and those values are clocked into output flops.
//
//   Optional feature: define SRAM_WAIT_EN to add sram_wait_n. With it, the
//   memory can stretch the access phase after WAIT_CYC cycles.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   addr, wr, cs, rw request: address, write data, valid (level), 1=read
//   rd, ready, busy  read data (held), completion pulse, in-flight flag
//   sram_*           SRAM bus: address, write data and its drive enable,
//                    read data, ce_n/oe_n/we_n strobes, wait_n (optional)
module sram_access_ctrl #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 32,
    parameter int SETUP_CYC = 1,
    parameter int WAIT_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr,
    input  logic              cs,
    input  logic              rw,
    output logic [DATA_W-1:0] rd,
    output logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
`ifdef SRAM_WAIT_EN
    input  logic              sram_wait_n,
`endif
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int MAXC  = (SETUP_CYC > WAIT_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((WAIT_CYC  > HOLD_CYC) ? WAIT_CYC  : HOLD_CYC);
    // Counter only ever holds N-1, so log2(MAXC) bits are enough.
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

    state_t            state, nstate;
    logic [CNT_W-1:0]  cnt, ncnt;
    logic              rw_lat;
    logic              rw_eff;
    logic              wait_ok;
    logic              n_ce_n, n_oe_n, n_we_n, n_dq_oe, n_ready, n_busy;

`ifdef SRAM_WAIT_EN
    assign wait_ok = sram_wait_n;
`else
    assign wait_ok = 1'b1;
`endif

    // On the accept cycle the latched direction is not yet valid.
    assign rw_eff = (state == IDLE) ? rw : rw_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
        end
    end

    always_comb begin
        nstate  = state;
        ncnt    = cnt;
        n_ce_n  = 1'b1;
        n_oe_n  = 1'b1;
        n_we_n  = 1'b1;
        n_dq_oe = 1'b0;
        n_ready = 1'b0;
        n_busy  = 1'b1;

        case (state)
            IDLE: begin
                if (cs) begin
                    nstate = SETUP;
                    ncnt   = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    nstate = ACCESS;
                    ncnt   = CNT_W'(WAIT_CYC - 1);
                end else begin
                    ncnt = cnt - CNT_W'(1);
                end
            end
            ACCESS: begin
                // At count 0 a low wait_n holds the strobe in place.
                if (cnt == '0) begin
                    if (wait_ok) begin
                        nstate = HOLD;
                        ncnt   = CNT_W'(HOLD_CYC - 1);
                    end
                end else begin
                    ncnt = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) nstate = DONE;
                else           ncnt   = cnt - CNT_W'(1);
            end
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase

        // Output values for the cycle we are about to enter.
        case (nstate)
            IDLE:  n_busy = 1'b0;
            SETUP: begin
                n_ce_n  = 1'b0;
                n_dq_oe = ~rw_eff;
            end
            ACCESS: begin
                n_ce_n  = 1'b0;
                n_oe_n  = ~rw_eff;
                n_we_n  = rw_eff;
                n_dq_oe = ~rw_eff;
            end
            HOLD: begin
                n_ce_n  = 1'b0;
                n_dq_oe = ~rw_eff;
            end
            DONE:    n_ready = 1'b1;
            default: n_busy  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd         <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            rw_lat     <= 1'b1;
        end else begin
            ready      <= n_ready;
            busy       <= n_busy;
            sram_dq_oe <= n_dq_oe;
            sram_ce_n  <= n_ce_n;
            sram_oe_n  <= n_oe_n;
            sram_we_n  <= n_we_n;
            if (state == IDLE && cs) begin
                sram_addr <= addr;
                rw_lat    <= rw;
                if (!rw) sram_dq_o <= wr;
            end
            // Capture on the edge that leaves ACCESS.
            if (state == ACCESS && nstate == HOLD && rw_lat)
                rd <= sram_dq_i;
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
module tb_sram_access_ctrl;
    localparam int S = 1, W = 2, H = 1;

    logic        clk = 1'b0;
    logic        rst, cs, rw;
    logic [21:0] addr;
    logic [31:0] wr, rd, sram_dq_o, sram_dq_i;
    logic [21:0] sram_addr;
    logic        ready, busy, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic        wait_n = 1'b1;
    logic        armed = 1'b0;
    int          vecs = 0, miss = 0;

    always #5 clk = ~clk;

    sram_access_ctrl dut (
        .clk(clk), .rst(rst), .addr(addr), .wr(wr), .cs(cs), .rw(rw),
        .rd(rd), .ready(ready), .busy(busy), .sram_addr(sram_addr),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
`ifdef SRAM_WAIT_EN
        .sram_wait_n(wait_n),
`endif
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a request is described by how many cycles have elapsed since it
    // was accepted (k) and how many extra access cycles the memory added (e).
    logic        m_active = 1'b0, m_rw = 1'b0;
    int          m_k = 0, m_e = 0;
    logic [21:0] m_addr = '0;
    logic [31:0] m_data = '0, m_rd = '0;

    always @(posedge clk) begin : model
        int k, e;
        k = m_k; e = m_e;
        if (rst) begin
            m_active <= 1'b0;
            m_rd     <= '0;
        end else if (!m_active) begin
            if (cs) begin
                m_active <= 1'b1; m_k <= 1; m_e <= 0;
                m_addr <= addr; m_data <= wr; m_rw <= rw;
            end
        end else begin
            if (k == S + W + e) begin
                if (!wait_n) e++;
                else if (m_rw) m_rd <= sram_dq_i;
            end
            if (k == S + W + e + H + 1) m_active <= 1'b0;
            m_k <= k + 1;
            m_e <= e;
        end
    end

    function automatic int phase();
        if (!m_active)            return 0;
        if (m_k <= S)             return 1;
        if (m_k <= S + W + m_e)   return 2;
        if (m_k <= S + W + m_e + H) return 3;
        return 4;
    endfunction

    always @(negedge clk) begin : compare
        int p;
        if (armed) begin
            p = phase();
            chk("m_ce_n",  sram_ce_n,  !(p >= 1 && p <= 3));
            chk("m_oe_n",  sram_oe_n,  !(p == 2 && m_rw));
            chk("m_we_n",  sram_we_n,  !(p == 2 && !m_rw));
            chk("m_dq_oe", sram_dq_oe, (p >= 1 && p <= 3) && !m_rw);
            chk("m_ready", ready, p == 4);
            chk("m_busy",  busy,  p != 0);
            chk("m_rd",    rd,    m_rd);
            if (p >= 1 && p <= 3) begin
                chk("m_addr", sram_addr, m_addr);
                if (!m_rw) chk("m_dq_o", sram_dq_o, m_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #2;
    endtask
    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; cs = 0; rw = 0; addr = '0; wr = '0; sram_dq_i = 32'hFFFF_FFFF;
        cyc(); cyc(); rst = 0; armed = 1'b1; cyc();

        // Write, cs pulse in cycle 0
        addr = 22'h3FFFFF; wr = 32'hDEADBEEF; rw = 0; cs = 1;
        neg(); chk("t2_c0_ce_n", sram_ce_n, 1);
        cyc(); cs = 0; addr = '0; wr = '0;                          // cycle 1
        neg(); chk("t2_c1_ce_n", sram_ce_n, 0); chk("t2_c1_we_n", sram_we_n, 1);
               chk("t2_c1_dq_o", sram_dq_o, 32'hDEADBEEF); chk("t2_c1_dq_oe", sram_dq_oe, 1);
        cyc(); neg(); chk("t2_c2_we_n", sram_we_n, 0);
        cyc(); neg(); chk("t2_c3_we_n", sram_we_n, 0);
        cyc(); neg(); chk("t2_c4_we_n", sram_we_n, 1); chk("t2_c4_ce_n", sram_ce_n, 0);
               chk("t2_c4_ready", ready, 0); chk("t2_c4_addr", sram_addr, 22'h3FFFFF);
        cyc(); neg(); chk("t2_c5_ready", ready, 1); chk("t2_c5_dq_oe", sram_dq_oe, 0);
        cyc(); neg(); chk("t2_c6_ready", ready, 0);
        cyc();

        // Read
        addr = 22'h000155; rw = 1; cs = 1;
        cyc(); cs = 0;                                              // cycle 1
        cyc(); sram_dq_i = 32'hA5A50F0F;                            // cycle 2
        neg(); chk("t3_c2_oe_n", sram_oe_n, 0);
        cyc(); cyc(); sram_dq_i = 32'hFFFF_FFFF;                    // cycle 4
        neg(); chk("t3_c4_oe_n", sram_oe_n, 1);
        cyc(); neg(); chk("t3_c5_ready", ready, 1); chk("t3_c5_rd", rd, 32'hA5A50F0F);
        cyc(); cyc();

        // Reset mid-idle for two cycles
        rst = 1; cyc(); cyc(); rst = 0;
        neg(); chk("t1_rd", rd, 0); chk("t1_busy", busy, 0); chk("t1_ce_n", sram_ce_n, 1);
        cyc();

        // Back-to-back: write then read with cs held high
        addr = 22'h2AAAAA; wr = 32'h12345678; rw = 0; cs = 1;
        cyc(); addr = 22'h000AAA; wr = 32'h0; rw = 1;                // cycle 1
        for (int c = 2; c <= 11; c++) begin
            cyc();
            if (c == 5) addr = 22'h111111;
            if (c == 8) sram_dq_i = 32'h0BADF00D;
            if (c == 9) begin addr = 22'h0; wr = 32'h55555555; rw = 0; end
            if (c == 10) sram_dq_i = 32'hFFFF_FFFF;
            if (c == 11) cs = 0;
            neg();
            if (c == 6)  chk("t4_c6_ce_n", sram_ce_n, 1);
            if (c == 7)  begin chk("t4_c7_ce_n", sram_ce_n, 0); chk("t4_c7_addr", sram_addr, 22'h111111); end
            if (c == 9)  chk("t4_c9_dq_oe", sram_dq_oe, 0);
            if (c == 11) begin chk("t4_c11_ready", ready, 1); chk("t4_c11_rd", rd, 32'h0BADF00D); end
        end
        cyc(); neg(); chk("t4_c12_busy", busy, 0);
        cyc();

        // Reset during ACCESS of a write, then a fresh request in cycle 4
        addr = 22'h000001; wr = 32'h11112222; rw = 0; cs = 1;
        cyc(); cs = 0;                                              // cycle 1
        cyc(); rst = 1;                                             // cycle 2
        cyc(); rst = 0;                                             // cycle 3
        neg(); chk("t5_c3_we_n", sram_we_n, 1); chk("t5_c3_ce_n", sram_ce_n, 1);
               chk("t5_c3_dq_oe", sram_dq_oe, 0); chk("t5_c3_busy", busy, 0);
        cyc(); addr = 22'h000002; wr = 32'h33334444; cs = 1;        // cycle 4
        for (int c = 5; c <= 10; c++) begin
            cyc(); cs = 0;
            neg(); chk($sformatf("t5_c%0d_ready", c), ready, c == 9);
        end

`ifdef SRAM_WAIT_EN
        // Stretched read: wait_n low in cycles 3-5
        cyc();
        addr = 22'h000077; rw = 1; cs = 1;
        for (int c = 1; c <= 9; c++) begin
            cyc(); cs = 0;
            wait_n = !(c >= 3 && c <= 5);
            sram_dq_i = (c == 6) ? 32'hC0FFEE11 : 32'hFFFF_FFFF;
            neg();
            chk($sformatf("t6_c%0d_oe_n", c), sram_oe_n, !(c >= 2 && c <= 6));
            chk($sformatf("t6_c%0d_ready", c), ready, c == 8);
            if (c == 8) chk("t6_rd", rd, 32'hC0FFEE11);
        end
        wait_n = 1'b1;
`endif
        cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
